ucode_sequencer: RTL
====================

# ucode_sequencer

Microprogram sequencer for the `tt_um_microcode` core. It sits directly upstream of the microcode ROM: it produces the registered micro-address `upc_o` each cycle and consumes the sequencing fields of the word the ROM returns. It supports:

- conditional branches
- opcode dispatch
- a bounded call/return stack
- wait states
- a sticky halt

## Interface

Parameters:
- `ADDR_W`, default 8: micro-address width.
- `STACK_DEPTH`, default 4: number of return-address entries.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  design enable; when 0, all state holds.
- `seq_op_i`  in  3  sequencing op from the ROM word: NEXT=0, JUMP=1, JCOND=2, CALL=3, RET=4, DISPATCH=5, WAIT=6, HALT=7.
- `target_i`  in  ADDR_W  branch/call target; for DISPATCH, supplies the table base.
- `cond_sel_i`  in  2  selects one of `flags_i[3:0]`.
- `cond_pol_i`  in  1  condition polarity; the branch is taken when `flags_i[cond_sel_i] == cond_pol_i`.
- `flags_i`  in  4  datapath flags (Z, C, N, external input).
- `opcode_i`  in  8  latched macro-instruction opcode.
- `wait_done_i`  in  1  wait-release strobe.
- `upc_o`  out  ADDR_W  current micro-address, registered.
- `halted_o`  out  1  sequencer is in HALT.
- `stack_err_o`  out  1  sticky: stack overflow or underflow occurred.

## Operation

- Two states: RUN and HALT.
  - Reset enters RUN.
  - HALT is left only by reset.
- In RUN with `ena`=1, the ops applied to the current `upc_o` (value P) are:
  - **NEXT:** P+1, modulo 2^ADDR_W (255 wraps to 0).
  - **JUMP:** `target_i`.
  - **JCOND:** `target_i` if the condition is true, else P+1.
  - **CALL:** push P+1 (mod 2^ADDR_W) onto the stack; go to `target_i`.
  - **RET:** pop; go to the popped address.
  - **DISPATCH:** go to {`target_i[ADDR_W-1:4]`, `opcode_i[3:0]`}, a 16-entry table aligned on 16.
  - **WAIT:** hold P while `wait_done_i`=0; go to P+1 in the cycle `wait_done_i`=1.
  - **HALT:** hold P; enter HALT; `halted_o`=1.
- Stack: LIFO of STACK_DEPTH entries, each ADDR_W wide, with an occupancy count from 0 to STACK_DEPTH.
  - CALL when the count equals STACK_DEPTH: no push, `stack_err_o` is set, the state goes to HALT, and `upc_o` holds P.
  - RET when the count is 0: no pop, `stack_err_o` is set, the state goes to HALT, and `upc_o` holds P.
- In HALT, all inputs are ignored and `upc_o`, the stack and the flags hold.
- `ena`=0: no state changes, whatever the op.
- `seq_op_i` is decoded as an exact enumeration; all 8 codes are defined.

## Timing

- Reset values (after a clock edge with `rst_n`=0):
  - `upc_o`=0, `halted_o`=0, `stack_err_o`=0.
  - Stack count 0; stack entry contents are don't-care.
- Latency: the op presented while `upc_o`=P determines `upc_o` at the next rising edge. This is one cycle per micro-instruction, assuming a combinational ROM read.
- Priority at each edge: `rst_n`=0 first, then `ena`=0 (hold), then HALT (hold), then op decode.
- Reset mid-operation (during WAIT, mid-call, or in HALT): the next cycle shows reset values and the stack is emptied.
- `wait_done_i` is sampled only while the current op is WAIT. A strobe that arrives in any other cycle is lost and not remembered.
- CALL followed immediately by RET in consecutive cycles is legal and returns to P+1.
- `stack_err_o` and `halted_o` update in the same edge as the faulting op.

## Structure

- `ucode_pkg` holds:
  - the `seq_op_t` enum (3-bit, values as listed above);
  - the flag-index constants FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_EXT=3;
  - the state enum {RUN, HALT}.
- Sub-module `ucode_stack`: a parameterised LIFO.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (top of stack), `full`, `empty`.
  - Same synchronous active-low reset as the sequencer.
  - The sequencer gates push/pop using `full`/`empty`.
- The next-address mux and state register live in `ucode_sequencer`.

## Test plan

- **Reset and NEXT:** reset, then NEXT for 260 cycles → `upc_o` counts 0…255, wraps to 0, and reaches 4; no flags set.
- **JCOND:** `flags_i`=4'b0001, `cond_sel_i`=0.
  - `cond_pol_i`=1, `target_i`=8'h40 at P=3 → `upc_o`=8'h40.
  - `cond_pol_i`=0 at the same P → `upc_o`=4.
- **Nested calls:** CALL 8'h10 at P=5, then CALL 8'h20 at P=8'h10, then RET, then RET → `upc_o` sequence 8'h10, 8'h20, 8'h11, 6.
- **Overflow:** 5 nested CALLs with STACK_DEPTH=4 → the 5th holds `upc_o`; `stack_err_o`=1 and `halted_o`=1 on the next edge; further ops are ignored until reset.
- **Dispatch:** DISPATCH with `target_i`=8'hA0, `opcode_i`=8'h3C → `upc_o`=8'hAC.
- **WAIT and enable:** WAIT at P=7 with `wait_done_i`=0 for 3 cycles → `upc_o` stays 7; a `wait_done_i` pulse gives 8.
  - Then `ena`=0 for 2 cycles with op JUMP → `upc_o` holds 8.
  - Assert `rst_n`=0 during the hold → `upc_o`=0 on the next edge.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared types for the microprogram sequencer: sequencing ops, flag indices, FSM states.
package ucode_pkg;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_JCOND    = 3'd2,
    OP_CALL     = 3'd3,
    OP_RET      = 3'd4,
    OP_DISPATCH = 3'd5,
    OP_WAIT     = 3'd6,
    OP_HALT     = 3'd7
  } seq_op_t;

  localparam int unsigned FLAG_Z   = 0;
  localparam int unsigned FLAG_C   = 1;
  localparam int unsigned FLAG_N   = 2;
  localparam int unsigned FLAG_EXT = 3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ucode_stack.sv
// Parameterised return-address LIFO; the caller must not push when full or pop when empty.
module ucode_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - CNT_W'(1));
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[top_idx];

  // Occupancy counter; reset empties the stack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Microprogram sequencer: next-address mux, RUN/HALT state and call/return stack control.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [2:0]        seq_op_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [1:0]        cond_sel_i,
  input  logic              cond_pol_i,
  input  logic [3:0]        flags_i,
  input  logic [7:0]        opcode_i,
  input  logic              wait_done_i,
  output logic [ADDR_W-1:0] upc_o,
  output logic              halted_o,
  output logic              stack_err_o
);

  seq_state_t        state;
  seq_op_t           op;
  logic              active;
  logic              cond_true;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] upc_nxt;
  logic              push;
  logic              pop;
  logic              fault;
  logic              go_halt;
  logic [ADDR_W-1:0] stk_dout;
  logic              stk_full;
  logic              stk_empty;
  logic              unused_opcode_hi;

  assign op               = seq_op_t'(seq_op_i);
  assign active           = ena && (state == ST_RUN);
  assign cond_true        = (flags_i[cond_sel_i] == cond_pol_i);
  assign pc_inc           = upc_o + ADDR_W'(1);
  assign unused_opcode_hi = ^opcode_i[7:4];

  ucode_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-address decode; stack traffic is only requested when the sequencer actually advances.
  always_comb begin
    upc_nxt = upc_o;
    push    = 1'b0;
    pop     = 1'b0;
    fault   = 1'b0;
    go_halt = 1'b0;
    if (active) begin
      case (op)
        OP_NEXT:     upc_nxt = pc_inc;
        OP_JUMP:     upc_nxt = target_i;
        OP_JCOND:    upc_nxt = cond_true ? target_i : pc_inc;
        OP_CALL: begin
          if (stk_full) begin
            fault = 1'b1;
          end else begin
            push    = 1'b1;
            upc_nxt = target_i;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            fault = 1'b1;
          end else begin
            pop     = 1'b1;
            upc_nxt = stk_dout;
          end
        end
        OP_DISPATCH: upc_nxt = {target_i[ADDR_W-1:4], opcode_i[3:0]};
        OP_WAIT:     upc_nxt = wait_done_i ? pc_inc : upc_o;
        OP_HALT:     go_halt = 1'b1;
        default:     upc_nxt = upc_o;
      endcase
    end
  end

  // State register: reset, then enable hold, then HALT hold, then decoded update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      upc_o       <= '0;
      halted_o    <= 1'b0;
      stack_err_o <= 1'b0;
    end else if (active) begin
      upc_o <= upc_nxt;
      if (fault || go_halt) begin
        state    <= ST_HALT;
        halted_o <= 1'b1;
      end
      if (fault) begin
        stack_err_o <= 1'b1;
      end
    end
  end

endmodule
